// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  typedef enum logic {IDLE, RUN} state_t;

  localparam int DIV_WIDTH_DEFAULT = 6;

  // The counter must be able to count the iterations 0..WIDTH-1.
  function automatic int ctr_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_restoring_divider_if #(parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, restore on borrow.
module div_step #(parameter int WIDTH = 6) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic             o_qbit
);
  logic [WIDTH-1:0] w_rs;
  logic [WIDTH:0]   w_t;

  // R before the shift is always below 2^(WIDTH-1), so dropping its msb loses nothing.
  assign w_rs   = {i_r[WIDTH-2:0], i_q_msb};
  assign w_t    = {1'b0, w_rs} - {1'b0, i_d};
  assign o_qbit = ~w_t[WIDTH];
  assign o_r    = o_qbit ? w_t[WIDTH-1:0] : w_rs;
endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// DIVZERO_EARLY_EN: finish a zero-divisor request one cycle after acceptance.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CTR_W = ctr_w(WIDTH);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_r, w_r, r_q, w_q, r_d, w_d;
  logic [WIDTH-1:0] r_quot, w_quot, r_rem, w_rem;
  logic [CTR_W-1:0] r_ctr, w_ctr;
  logic             r_busy, w_busy, r_done, w_done, r_dbz, w_dbz;
  logic [WIDTH-1:0] w_step_r;
  logic             w_qbit, w_last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r    (r_r),
    .i_q_msb(r_q[WIDTH-1]),
    .i_d    (r_d),
    .o_r    (w_step_r),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_state = r_state;
    w_r     = r_r;
    w_q     = r_q;
    w_d     = r_d;
    w_ctr   = r_ctr;
    w_quot  = r_quot;
    w_rem   = r_rem;
    w_busy  = r_busy;
    w_dbz   = r_dbz;
    w_done  = 1'b0;
    w_last  = (r_ctr == CTR_W'(WIDTH - 1));
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_q     = bus.dividend;
          w_d     = bus.divisor;
          w_r     = '0;
          w_ctr   = '0;
          w_dbz   = 1'b0;
          w_busy  = 1'b1;
          w_state = RUN;
        end
      end
      RUN: begin
`ifdef DIVZERO_EARLY_EN
        if (r_d == '0) begin
          // Q still holds the untouched dividend on the first RUN cycle.
          w_quot  = '1;
          w_rem   = r_q;
          w_dbz   = 1'b1;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else
`endif
        begin
          w_r   = w_step_r;
          w_q   = {r_q[WIDTH-2:0], w_qbit};
          w_ctr = r_ctr + CTR_W'(1);
          if (w_last) begin
            w_quot  = {r_q[WIDTH-2:0], w_qbit};
            w_rem   = w_step_r;
            w_dbz   = (r_d == '0);
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = IDLE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_ctr   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_r     <= w_r;
      r_q     <= w_q;
      r_d     <= w_d;
      r_ctr   <= w_ctr;
      r_quot  <= w_quot;
      r_rem   <= w_rem;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_dbz   <= w_dbz;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and swept checks of seq_restoring_divider at WIDTH=6.
module tb_seq_restoring_divider;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_err = 0;
  int   n_done = 0, n_exp_done = 0;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) n_done++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called one step after an edge; returns cycles until done is seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic run_div(input string tag, input int n, input int d,
                         input int eq, input int er, input int edbz, input int elat);
    int lat;
    bus.start = 1'b1; bus.dividend = W'(n); bus.divisor = W'(d);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    wait_done(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, edbz);
    n_exp_done++;
  endtask

  initial begin
    int lat, seen, n, d, zlat;
`ifdef DIVZERO_EARLY_EN
    zlat = 1;
`else
    zlat = W;
`endif
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div("d45_7", 45, 7, 6, 3, 0, W);
    @(posedge clk); #1;
    chk("done_pulse", bus.done, 0);
    chk("hold_q", bus.quotient, 6);

    // Back-to-back with start held: second request is accepted in the done cycle.
    bus.start = 1'b1; bus.dividend = 6'd63; bus.divisor = 6'd1;
    @(posedge clk); #1;
    bus.dividend = 6'd5; bus.divisor = 6'd9;
    wait_done(lat);
    chk("b2b1_lat", lat, W);
    chk("b2b1_q", bus.quotient, 63);
    chk("b2b1_r", bus.remainder, 0);
    n_exp_done++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b2_busy", bus.busy, 1);
    chk("b2b2_done", bus.done, 0);
    wait_done(lat);
    chk("b2b2_lat", lat, W);
    chk("b2b2_q", bus.quotient, 0);
    chk("b2b2_r", bus.remainder, 5);
    n_exp_done++;

    run_div("dz", 20, 0, 63, 20, 1, zlat);
    run_div("d63_63", 63, 63, 1, 0, 0, W);
    run_div("d0_5", 0, 5, 0, 0, 0, W);
    run_div("d62_32", 62, 32, 1, 30, 0, W);
    run_div("after_dz", 7, 2, 3, 1, 0, W);

    // A start pulse while busy must be ignored.
    bus.start = 1'b1; bus.dividend = 6'd50; bus.divisor = 6'd4;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 6'd33; bus.divisor = 6'd11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 6'd9; bus.divisor = 6'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_busy", bus.busy, 1);
    wait_done(lat);
    chk("ign_lat", lat, W - 3);
    chk("ign_q", bus.quotient, 12);
    chk("ign_r", bus.remainder, 2);
    n_exp_done++;

    // Asynchronous abort mid-operation.
    bus.start = 1'b1; bus.dividend = 6'd60; bus.divisor = 6'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_q", bus.quotient, 0);
    chk("abort_r", bus.remainder, 0);
    chk("abort_done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_div("d60_5", 60, 5, 12, 0, 0, W);

    for (int i = 0; i < 2000; i++) begin
      n = $urandom_range(63, 0);
      d = $urandom_range(63, 1);
      bus.start = 1'b1; bus.dividend = W'(n); bus.divisor = W'(d);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.dividend = W'($urandom); bus.divisor = W'($urandom);
      wait_done(lat);
      n_exp_done++;
      chk("rnd_lat", lat, W);
      chk("rnd_inv", bus.quotient * d + bus.remainder, n);
      chk("rnd_rlt", (int'(bus.remainder) < d) ? 1 : 0, 1);
      chk("rnd_q", bus.quotient, n / d);
    end

    @(posedge clk); #1;
    chk("done_count", n_done, n_exp_done);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
